// File: rtl/answer_judge_pkg.sv
// Shared definitions for the 1P digit game: the controller state encoding and the default timing constants.
// Latency: none (package only).
// Backpressure: none (package only).
package answer_judge_pkg;

    // Controller state encoding, 2 bits wide. The READY digit generator and
    // the display block decode these same values.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INPUT  = 2'd1,
        ST_JUDGE  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    localparam int CYC_PER_SEC_DEF = 50_000_000;  // core clocks per 1 s countdown tick
    localparam int TIME_LIMIT_DEF  = 9;           // seconds allowed per guess
    localparam int MAX_DIGIT_DEF   = 9;           // largest enterable digit

endpackage

// File: rtl/answer_judge_sec_tick.sv
// Seconds prescaler: counts 0..CYC_PER_SEC-1 while enabled and flags the last count as a tick.
// Latency: tick is combinational from the registered count, so it is high for the whole last cycle of each second.
// Backpressure: none. clr overrides en; the count holds while en is low.
// Ports: clk, rst_n (async active-low), clr (sync clear), en (count enable), tick (end-of-second strobe).
module answer_judge_sec_tick #(
    parameter int CYC_PER_SEC = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CNT_W = (CYC_PER_SEC > 1) ? $clog2(CYC_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYC_PER_SEC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/answer_judge.sv
// Player-side answer judge: latches the target digit at START, takes a guess via UP/DOWN/ENTER under a countdown, reports CORRECT/WRONG/TIMEOUT.
// Latency: ENTER_1P sampled on edge N -> JUDGE; result flag and DONE are visible after edge N+1. All outputs are registered.
// Backpressure: none. Button pulses are consumed in the cycle they arrive; START_1P is ignored while BUSY.
// Ports: CLK, RST (async active-low); START_1P/TARGET begin a round; UP_1P/DOWN_1P/ENTER_1P edit and submit the guess;
//        GUESS, TIME_LEFT, BUSY, CORRECT, WRONG, TIMEOUT, DONE report state to the controller and the display.
module answer_judge
    import answer_judge_pkg::*;
#(
    parameter int CYC_PER_SEC = CYC_PER_SEC_DEF,
    parameter int TIME_LIMIT  = TIME_LIMIT_DEF,
    parameter int MAX_DIGIT   = MAX_DIGIT_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START_1P,
    input  logic [3:0] TARGET,
    input  logic       UP_1P,
    input  logic       DOWN_1P,
    input  logic       ENTER_1P,
    output logic [3:0] GUESS,
    output logic [3:0] TIME_LEFT,
    output logic       BUSY,
    output logic       CORRECT,
    output logic       WRONG,
    output logic       TIMEOUT,
    output logic       DONE
);

    localparam logic [3:0] TIME_INIT = 4'(TIME_LIMIT);
    localparam logic [3:0] DIGIT_MAX = 4'(MAX_DIGIT);

    state_e     state_q,   state_d;
    logic [3:0] target_q,  target_d;
    logic [3:0] guess_q,   guess_d;
    logic [3:0] time_q,    time_d;
    logic       busy_q,    busy_d;
    logic       correct_q, correct_d;
    logic       wrong_q,   wrong_d;
    logic       timeout_q, timeout_d;
    logic       done_q,    done_d;

    logic start_round;
    logic sec_tick;
    logic last_tick;

    // A round can only be (re)started from IDLE or RESULT.
    assign start_round = START_1P && ((state_q == ST_IDLE) || (state_q == ST_RESULT));
    assign last_tick   = sec_tick && (time_q <= 4'd1);

    answer_judge_sec_tick #(
        .CYC_PER_SEC (CYC_PER_SEC)
    ) u_sec_tick (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (start_round),
        .en    (state_q == ST_INPUT),
        .tick  (sec_tick)
    );

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        guess_d   = guess_q;
        time_d    = time_q;
        busy_d    = busy_q;
        correct_d = correct_q;
        wrong_d   = wrong_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_RESULT: begin
                if (start_round) begin
                    state_d   = ST_INPUT;
                    target_d  = TARGET;
                    guess_d   = 4'd0;
                    time_d    = TIME_INIT;
                    busy_d    = 1'b1;
                    correct_d = 1'b0;
                    wrong_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end

            ST_INPUT: begin
                // The countdown keeps running on the ENTER cycle, so an ENTER
                // that lands on the final tick still shows TIME_LEFT = 0.
                if (sec_tick) begin
                    time_d = last_tick ? 4'd0 : time_q - 4'd1;
                end

                if (ENTER_1P) begin
                    state_d = ST_JUDGE;
                end else if (last_tick) begin
                    state_d   = ST_RESULT;
                    busy_d    = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                end else if (UP_1P && !DOWN_1P) begin
                    guess_d = (guess_q == DIGIT_MAX) ? 4'd0 : guess_q + 4'd1;
                end else if (DOWN_1P && !UP_1P) begin
                    guess_d = (guess_q == 4'd0) ? DIGIT_MAX : guess_q - 4'd1;
                end
            end

            ST_JUDGE: begin
                // Out-of-range targets are compared as-is and so never match.
                state_d   = ST_RESULT;
                busy_d    = 1'b0;
                correct_d = (guess_q == target_q);
                wrong_d   = (guess_q != target_q);
                done_d    = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            target_q  <= 4'd0;
            guess_q   <= 4'd0;
            time_q    <= 4'd0;
            busy_q    <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            guess_q   <= guess_d;
            time_q    <= time_d;
            busy_q    <= busy_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    assign GUESS     = guess_q;
    assign TIME_LEFT = time_q;
    assign BUSY      = busy_q;
    assign CORRECT   = correct_q;
    assign WRONG     = wrong_q;
    assign TIMEOUT   = timeout_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: expected round results are queued by the stimulus and
// checked by a monitor on every DONE pulse; level checks cover reset, editing and timing.
module tb_answer_judge;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START_1P = 1'b0;
    logic [3:0] TARGET = 4'd0;
    logic       UP_1P = 1'b0;
    logic       DOWN_1P = 1'b0;
    logic       ENTER_1P = 1'b0;
    logic [3:0] GUESS;
    logic [3:0] TIME_LEFT;
    logic       BUSY;
    logic       CORRECT;
    logic       WRONG;
    logic       TIMEOUT;
    logic       DONE;

    typedef struct packed {
        logic       c;
        logic       w;
        logic       t;
        logic [3:0] g;
    } res_t;

    res_t exp_q[$];
    int   n_chk  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    answer_judge #(
        .CYC_PER_SEC (10),
        .TIME_LIMIT  (9),
        .MAX_DIGIT   (9)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START_1P  (START_1P),
        .TARGET    (TARGET),
        .UP_1P     (UP_1P),
        .DOWN_1P   (DOWN_1P),
        .ENTER_1P  (ENTER_1P),
        .GUESS     (GUESS),
        .TIME_LEFT (TIME_LEFT),
        .BUSY      (BUSY),
        .CORRECT   (CORRECT),
        .WRONG     (WRONG),
        .TIMEOUT   (TIMEOUT),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every DONE cycle must match the oldest queued round result.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_done: got DONE=1 expected no result pending");
            end else begin
                res_t e;
                e = exp_q.pop_front();
                n_done++;
                chk("round_result", {CORRECT, WRONG, TIMEOUT, GUESS}, e);
            end
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Inputs change just after a falling edge; the DUT samples them on the next rising edge.
    task automatic start(input logic [3:0] t);
        START_1P = 1'b1;
        TARGET   = t;
        @(negedge CLK);
        START_1P = 1'b0;
        TARGET   = 4'hF;
    endtask

    task automatic press_up();
        UP_1P = 1'b1;
        @(negedge CLK);
        UP_1P = 1'b0;
    endtask

    task automatic press_down();
        DOWN_1P = 1'b1;
        @(negedge CLK);
        DOWN_1P = 1'b0;
    endtask

    task automatic press_enter();
        ENTER_1P = 1'b1;
        @(negedge CLK);
        ENTER_1P = 1'b0;
    endtask

    initial begin
        #1 RST = 1'b0;
        nclk(2);
        chk("reset_outputs", {GUESS, TIME_LEFT, BUSY, CORRECT, WRONG, TIMEOUT, DONE}, 32'd0);
        RST = 1'b1;
        nclk(1);
        chk("idle_after_reset", {BUSY, DONE}, 32'd0);

        // 1: three UPs to the target, ENTER, CORRECT two edges later.
        start(4'd3);
        chk("t1_start", {BUSY, GUESS, TIME_LEFT}, {23'd0, 1'b1, 4'd0, 4'd9});
        repeat (3) begin
            press_up();
            nclk(1);
        end
        chk("t1_guess", GUESS, 32'd3);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 4'd3});
        press_enter();
        chk("t1_judge_cycle", {BUSY, CORRECT, WRONG, TIMEOUT, DONE}, 32'b10000);
        nclk(1);
        chk("t1_result", {BUSY, CORRECT, WRONG, TIMEOUT, DONE}, 32'b01001);
        nclk(1);
        chk("t1_done_one_cycle", {DONE, CORRECT}, 32'b01);

        // 2: wrap down, wrap up, simultaneous UP+DOWN, wrong answer.
        start(4'd5);
        press_down();
        chk("t2_down_wrap", GUESS, 32'd9);
        press_up();
        chk("t2_up_wrap", GUESS, 32'd0);
        UP_1P   = 1'b1;
        DOWN_1P = 1'b1;
        nclk(1);
        UP_1P   = 1'b0;
        DOWN_1P = 1'b0;
        chk("t2_up_down_same", GUESS, 32'd0);
        exp_q.push_back({1'b0, 1'b1, 1'b0, 4'd0});
        press_enter();
        nclk(1);
        chk("t2_wrong", {CORRECT, WRONG, TIMEOUT, BUSY}, 32'b0100);

        // 3: no buttons, countdown 9..0 at 10 cycles per step, then TIMEOUT.
        start(4'd2);
        chk("t3_time_init", TIME_LEFT, 32'd9);
        exp_q.push_back({1'b0, 1'b0, 1'b1, 4'd0});
        for (int k = 1; k <= 90; k++) begin
            nclk(1);
            if ((k % 10 == 0) || (k % 10 == 9)) begin
                chk($sformatf("t3_time_at_%0d", k), TIME_LEFT, 32'(9 - k / 10));
            end
        end
        chk("t3_timeout", {BUSY, CORRECT, WRONG, TIMEOUT, DONE}, 32'b00011);

        // 4: ENTER on the very cycle of the final tick; ENTER wins.
        start(4'd0);
        nclk(89);
        chk("t4_before_last_tick", {TIME_LEFT, BUSY}, {27'd0, 4'd1, 1'b1});
        exp_q.push_back({1'b1, 1'b0, 1'b0, 4'd0});
        press_enter();
        chk("t4_judge", {TIME_LEFT, TIMEOUT, BUSY}, {26'd0, 4'd0, 1'b0, 1'b1});
        nclk(1);
        chk("t4_result", {CORRECT, TIMEOUT, TIME_LEFT}, {26'd0, 1'b1, 1'b0, 4'd0});

        // 5: restart from RESULT, then a START mid-INPUT must be ignored.
        start(4'd7);
        chk("t5_restart", {CORRECT, WRONG, TIMEOUT, GUESS, TIME_LEFT, BUSY},
            {20'd0, 3'b000, 4'd0, 4'd9, 1'b1});
        repeat (2) begin
            press_up();
            nclk(1);
        end
        start(4'd1);
        chk("t5_start_ignored", {GUESS, BUSY}, {27'd0, 4'd2, 1'b1});
        repeat (5) begin
            press_up();
            nclk(1);
        end
        chk("t5_guess", GUESS, 32'd7);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 4'd7});
        press_enter();
        nclk(1);
        chk("t5_correct_kept_target", {CORRECT, WRONG}, 32'b10);

        // 6: asynchronous reset mid-round aborts without DONE.
        start(4'd4);
        repeat (4) begin
            press_up();
            nclk(1);
        end
        chk("t6_guess", GUESS, 32'd4);
        for (int i = 0; i < 60 && TIME_LEFT != 4'd6; i++) nclk(1);
        chk("t6_time_reached", {TIME_LEFT, BUSY}, {27'd0, 4'd6, 1'b1});
        #2 RST = 1'b0;
        #1 chk("t6_async_reset", {GUESS, TIME_LEFT, BUSY, CORRECT, WRONG, TIMEOUT, DONE}, 32'd0);
        nclk(3);
        RST = 1'b1;
        nclk(12);
        chk("t6_idle_after_release", {GUESS, TIME_LEFT, BUSY, DONE}, 32'd0);
        press_up();
        chk("t6_idle_ignores_up", GUESS, 32'd0);
        nclk(2);

        chk("done_count", n_done, 32'd5);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
